// File: rtl/shift_pkg.sv
// Shared constants for the shift execute stage: op encodings and default sizing.
package shift_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  localparam int N_DEF     = 16;
  localparam int C_DEF     = 4;
  localparam int T_DEF     = 3;
  localparam int DEPTH_DEF = 2;

endpackage

// File: rtl/shift_exec_stage_if.sv
// Request/result handshake bundle between operand fetch, the shift stage and writeback.
interface shift_exec_stage_if
  import shift_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF,
  parameter int T = T_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [C-1:0] in_cnt;
  logic [1:0]   in_op;
  logic [T-1:0] in_tag;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [T-1:0] out_tag;
  logic         out_zero;

  modport master (
    output in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );

endinterface

// File: rtl/shift_exec_stage_shifter.sv
// Combinational N-bit barrel shifter: rotate left, logical left/right, arithmetic right.
module shifter
  import shift_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic [N-1:0] i_data,
  input  logic [C-1:0] i_cnt,
  input  logic [1:0]   i_op,
  output logic [N-1:0] o_data,
  output logic         o_zero
);

  // Upper half of the doubled word shifted left is exactly the left rotation.
  function automatic logic [N-1:0] rol_f(input logic [N-1:0] d, input logic [C-1:0] c);
    logic [2*N-1:0] dbl;
    dbl = {d, d} << c;
    return dbl[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] sra_f(input logic [N-1:0] d, input logic [C-1:0] c);
    logic signed [N-1:0] s;
    s = signed'(d);
    return s >>> c;
  endfunction

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_ROL:  o_data = rol_f(i_data, i_cnt);
      OP_SLL:  o_data = i_data << i_cnt;
      OP_SRA:  o_data = sra_f(i_data, i_cnt);
      OP_SRL:  o_data = i_data >> i_cnt;
      default: o_data = i_data;
    endcase
  end

  assign o_zero = (o_data == '0);

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper: operand register -> barrel shifter -> in-order result FIFO.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int C     = C_DEF,
  parameter int T     = T_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  shift_exec_stage_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic         r_vld_p0;
  logic [N-1:0] r_data_p0;
  logic [C-1:0] r_cnt_p0;
  logic [1:0]   r_op_p0;
  logic [T-1:0] r_tag_p0;

  logic [N-1:0] w_res;
  logic         w_zero;

  logic [N-1:0] r_mem_data [DEPTH];
  logic [T-1:0] r_mem_tag  [DEPTH];
  logic         r_mem_zero [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_out_valid;
  logic w_pop;
  logic w_adv;
  logic w_in_ready;
  logic w_accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake decisions depend only on valid/count state, never on operand data.
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_adv       = r_vld_p0 && ((r_count < DEPTH_C) || w_pop);
  assign w_in_ready  = !r_vld_p0 || w_adv;
  assign w_accept    = bus.in_valid && w_in_ready;

  // Stage p0: operand register feeding the shifter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data_p0 <= bus.in_data;
      r_cnt_p0  <= bus.in_cnt;
      r_op_p0   <= bus.in_op;
      r_tag_p0  <= bus.in_tag;
    end
  end

  shifter #(.N(N), .C(C)) u_shifter (
    .i_data (r_data_p0),
    .i_cnt  (r_cnt_p0),
    .i_op   (r_op_p0),
    .o_data (w_res),
    .o_zero (w_zero)
  );

  // Stage p1: result FIFO storage.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mem_data[r_wr_ptr] <= w_res;
      r_mem_tag[r_wr_ptr]  <= r_tag_p0;
      r_mem_zero[r_wr_ptr] <= w_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept)   r_vld_p0 <= 1'b1;
      else if (w_adv) r_vld_p0 <= 1'b0;
      if (w_adv) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_adv, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty FIFO presents zeros so stale or uninitialised entries never leak out.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.out_tag   = w_out_valid ? r_mem_tag[r_rd_ptr]  : '0;
  assign bus.out_zero  = w_out_valid ? r_mem_zero[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed scenarios plus randomised scoreboard run.
module tb_shift_exec_stage;
  import shift_pkg::*;

  localparam int N     = 16;
  localparam int C     = 4;
  localparam int T     = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_exec_stage_if #(.N(N), .C(C), .T(T)) bus ();

  shift_exec_stage #(.N(N), .C(C), .T(T), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_got  = 0;
  logic [T+N:0] exp_q [$];

  // Bit-by-bit reference: each result bit is picked from its source position.
  function automatic logic [N:0] ref_shift(input logic [N-1:0] d, input int c, input logic [1:0] op);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (op)
        OP_ROL: r[i] = d[(i - c + N) % N];
        OP_SLL: if (i >= c) r[i] = d[i - c];
        OP_SRA: r[i] = (i + c < N) ? d[i + c] : d[N-1];
        default: if (i + c < N) r[i] = d[i + c];
      endcase
    end
    return {(r == '0), r};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] d, input logic [C-1:0] c,
                       input logic [1:0] op, input logic [T-1:0] tag);
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_cnt   = c;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  // One clock with scoreboard tracking of accepted requests and popped results.
  task automatic cyc(input logic iv, input logic [N-1:0] d, input logic [C-1:0] c,
                     input logic [1:0] op, input logic [T-1:0] tag, input logic ordy,
                     output logic acc, output logic pop);
    drive(iv, d, c, op, tag);
    bus.out_ready = ordy;
    #1;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    if (pop) begin
      if (exp_q.size() == 0) check("pop_with_nothing_pending", exp_q.size(), 1);
      else check("result", {bus.out_tag, bus.out_zero, bus.out_data}, exp_q.pop_front());
      n_got++;
    end
    if (acc) exp_q.push_back({tag, ref_shift(d, int'(c), op)});
    tick();
  endtask

  logic [N-1:0] d4 [4] = '{16'h8000, 16'h8000, 16'h00FF, 16'h8000};
  logic [C-1:0] c4 [4] = '{4'd15, 4'd15, 4'd8, 4'd1};
  logic [1:0]  op4 [4] = '{OP_SRA, OP_SRL, OP_SLL, OP_SLL};
  logic [N-1:0] e4 [4] = '{16'hFFFF, 16'h0001, 16'hFF00, 16'h0000};

  initial begin
    logic acc, pop;
    int t, got0, sent, cycles;

    rst = 1'b1;
    drive(1'b0, '0, '0, 2'b00, '0);
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_out_zero",  bus.out_zero,  0);
    tick();
    rst = 1'b0;

    // Single rotate: result visible two cycles after acceptance.
    drive(1'b1, 16'h8001, 4'd1, OP_ROL, 3'd3);
    bus.out_ready = 1'b1;
    #1;
    check("rol_in_ready", bus.in_ready, 1);
    tick();
    drive(1'b0, '0, '0, 2'b00, '0);
    check("rol_lat_early", bus.out_valid, 0);
    tick();
    check("rol_valid", bus.out_valid, 1);
    check("rol_data",  bus.out_data, 16'h0003);
    check("rol_tag",   bus.out_tag, 3);
    check("rol_zero",  bus.out_zero, 0);
    tick();
    check("rol_drained", bus.out_valid, 0);

    // Four ops back-to-back at full throughput.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d4[i], c4[i], op4[i], T'(i));
      #1;
      check("b2b_in_ready", bus.in_ready, 1);
      tick();
      if (i >= 1) begin
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_data", bus.out_data, e4[i-1]);
        check("b2b_tag",  bus.out_tag, i - 1);
      end
    end
    drive(1'b0, '0, '0, 2'b00, '0);
    tick();
    check("b2b_valid3", bus.out_valid, 1);
    check("b2b_data3",  bus.out_data, 16'h0000);
    check("b2b_zero3",  bus.out_zero, 1);
    check("b2b_tag3",   bus.out_tag, 3);
    tick();
    check("b2b_drained", bus.out_valid, 0);

    // Backpressure: capacity is DEPTH+1 requests.
    bus.out_ready = 1'b0;
    t = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'h1000 + N'(t), 4'd0, OP_SLL, T'(t));
      #1;
      check("bp_in_ready", bus.in_ready, (k < 3) ? 1 : 0);
      if (bus.in_ready) t++;
      tick();
    end
    check("bp_accepted", t, 3);
    for (int k = 0; k < 2; k++) begin
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_tag",   bus.out_tag, 0);
      check("bp_hold_data",  bus.out_data, 16'h1000);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_tag",   bus.out_tag, k);
      check("bp_out_data",  bus.out_data, 16'h1000 + k);
      tick();
      drive(1'b0, '0, '0, 2'b00, '0);
    end
    check("bp_drained", bus.out_valid, 0);

    // Simultaneous push and pop while full: no bubble.
    exp_q.delete();
    for (int k = 0; k < 3; k++)
      cyc(1'b1, N'($urandom), C'($urandom), 2'($urandom), T'(k), 1'b0, acc, pop);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, N'($urandom), C'($urandom), 2'($urandom), T'(k + 3), 1'b1, acc, pop);
      check("pp_accept", acc, 1);
      check("pp_pop", pop, 1);
    end
    for (int k = 0; k < 10 && exp_q.size() != 0; k++)
      cyc(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, pop);
    check("pp_drained", exp_q.size(), 0);

    // Asynchronous reset with requests in flight.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, N'($urandom), C'($urandom), 2'($urandom), T'(k), 1'b0, acc, pop);
    drive(1'b0, '0, '0, 2'b00, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready",  bus.in_ready, 1);
    check("arst_out_data",  bus.out_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    got0 = n_got;
    cyc(1'b1, 16'h1234, 4'd4, OP_SLL, 3'd5, 1'b1, acc, pop);
    check("arst_first_accept", acc, 1);
    for (int k = 0; k < 5; k++)
      cyc(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, pop);
    check("arst_single_output", n_got - got0, 1);

    // Randomised run against the reference model.
    got0 = n_got;
    sent = 0;
    cycles = 0;
    while (sent < 2000 && cycles < 20000) begin
      cyc(($urandom % 4) != 0, N'($urandom), C'($urandom), 2'($urandom), T'(sent),
          ($urandom % 8) < 6, acc, pop);
      if (acc) sent++;
      cycles++;
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      cyc(1'b0, '0, '0, 2'b00, '0, 1'b1, acc, pop);
    check("rand_sent", sent, 2000);
    check("rand_received", n_got - got0, 2000);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_final_idle", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Registered execute-stage wrapper that feeds the combinational 16-bit barrel shifter and consumes its result.
- Accepts shift requests over a valid/ready handshake and latches the operands into an operand register that drives the shifter core.
- Captures the shifter result, a zero flag and a request tag into a small in-order result FIFO.
- Sits between instruction decode/operand fetch and writeback; isolates the shifter from upstream stalls and downstream backpressure.

Parameters:
- N, 16, data width; must equal 2**C.
- C, 4, shift-count width.
- T, 3, tag width; the tag is carried unchanged from request to result.
- DEPTH, 2, result FIFO entries; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_data  input  N  operand to shift.
- in_cnt  input  C  shift/rotate amount.
- in_op  input  2  operation: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
- in_tag  input  T  request identifier.
- out_valid  output  1  head-of-FIFO result present.
- out_ready  input  1  consumer takes the result.
- out_data  output  N  shifted result.
- out_tag  output  T  tag of the result.
- out_zero  output  1  1 when out_data is all zeros.

Behaviour:
- Reset (rst asserted, asynchronous):
  - op_valid=0, FIFO count=0, read/write pointers=0.
  - out_valid=0, in_ready=1.
  - out_data, out_tag and out_zero read 0 while empty; operand register contents are don't-care.
  - Reset mid-operation discards all in-flight requests with no partial output. First acceptance is possible on the first edge after deassertion.
- Accept: the rising edge where in_valid&&in_ready loads in_data, in_cnt, in_op and in_tag into the operand register and sets op_valid.
- Shift core, combinational from the operand register:
  - Rotate left: (d<<c)|(d>>(N-c)); c=0 returns d.
  - Shift left logical: zero fill.
  - Shift right arithmetic: fill with d[N-1].
  - Shift right logical: zero fill.
  - Count 0 returns d unchanged for every op.
- Advance: advance = op_valid && (count<DEPTH || (out_valid&&out_ready)). On advance the shifter result, zero flag and tag are written at the write pointer and op_valid clears, unless a new request is accepted in the same edge.
- in_ready = !op_valid || advance. This gives a combinational path out_ready -> in_ready, which is permitted.
- Pop: out_valid&&out_ready advances the read pointer. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Latency: accepted at edge k, result written at edge k+1, out_valid visible in the cycle after edge k+1. Minimum 2 cycles, throughput 1 per cycle when out_ready is held high.
- Full: count==DEPTH with out_ready low holds the operand register (op_valid stays 1) and in_ready=0. Capacity is DEPTH+1 requests.
- Empty: out_valid=0; out_ready is ignored.
- Ordering: strictly in order, no drops, no duplicates. Results hold stable while out_valid&&!out_ready.
- in_data/in_cnt/in_op/in_tag are ignored when in_valid=0. X on those ports must never propagate to out_valid.

Decomposition:
- Package shift_pkg:
  - Op encoding constants: OP_ROL=2'b00, OP_SLL=2'b01, OP_SRA=2'b10, OP_SRL=2'b11.
  - Defaults for N, C and DEPTH.
- Natural sub-module: the combinational shifter core (shifter), instantiated once and driven by the operand register.
- The FIFO stays inline; it is too small to justify a separate module.

Test Plan:
- ROL in_data=16'h8001, cnt=1, tag=3, out_ready=1 -> out_data=16'h0003, out_tag=3, out_zero=0, out_valid exactly 2 cycles after acceptance.
- SRA 16'h8000 cnt=15 -> 16'hFFFF. SRL 16'h8000 cnt=15 -> 16'h0001. SLL 16'h00FF cnt=8 -> 16'hFF00. SLL 16'h8000 cnt=1 -> 16'h0000 with out_zero=1. All four back-to-back, one per cycle, in order.
- Backpressure:
  - out_ready=0, offer tags 0..3 continuously -> tags 0, 1 and 2 accepted; in_ready=0 from the cycle after tag 2 is accepted; tag 3 held off.
  - Raise out_ready -> outputs tags 0, 1, 2, 3 in order, one per cycle, data stable while stalled.
- Simultaneous push/pop at full FIFO with out_ready=1 -> in_ready stays 1, no bubble, no loss; count holds at 2.
- Assert rst for 1 cycle while 3 requests are in flight -> out_valid=0 immediately (asynchronous), in_ready=1. Next request after reset is the only output observed.
- Randomised 2000 requests against a reference model using the same op equations -> zero mismatches; every tag appears once, in order.
